// File: rtl/audio_video_pkg.sv
// Shared types and constants for the audio/video sequencing path.
package audio_video_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    PLAY  = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef enum logic {
    SCORE = 1'b0,
    RAND  = 1'b1
  } mode_t;

  localparam int NOTE_W    = 5;
  localparam int LEN_W     = 4;
  localparam int NUM_NOTES = 24;

  // Map a raw 5-bit random value onto the 0..NUM_NOTES-1 note range.
  function automatic logic [NOTE_W-1:0] fold_note(input logic [NOTE_W-1:0] r);
    if (r >= NOTE_W'(NUM_NOTES)) begin
      fold_note = r - NOTE_W'(NUM_NOTES);
    end else begin
      fold_note = r;
    end
  endfunction

endpackage

// File: rtl/score_player_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), shifting left with feedback into bit 0.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step,
  output logic [15:0] q
);

  logic [15:0] r_q;
  logic        w_fb;

  assign w_fb = r_q[15] ^ r_q[13] ^ r_q[12] ^ r_q[10];

  // LFSR state register, advanced only on request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= SEED;
    end else if (step) begin
      r_q <= {r_q[14:0], w_fb};
    end else begin
      r_q <= r_q;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/score_player.sv
// Note sequencer: plays a score ROM or LFSR-generated notes, strobing finish_len per note.
module score_player
  import audio_video_pkg::*;
#(
  parameter int          ADDR_W    = 7,
  parameter int          TICK_DIV  = 12500000,
  parameter int          RAND_LEN  = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Init_audio_video,
  input  logic              Do_rand_audio_video,
  input  logic              Do_save_audio_video,
  output logic [ADDR_W-1:0] score_addr,
  input  logic [8:0]        score_q,
  output logic [NOTE_W-1:0] note,
  output logic              finish_len,
  output logic              playing,
  output logic              done
);

  localparam int                PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0]  PRE_TOP  = PRE_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  state_t              r_state, w_state_nxt;
  mode_t               r_mode, w_mode_nxt;
  logic [NOTE_W-1:0]   r_note, w_note_nxt;
  logic [LEN_W-1:0]    r_len, w_len_nxt;
  logic [LEN_W-1:0]    r_unit, w_unit_nxt;
  logic [PRE_W-1:0]    r_pre, w_pre_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic                r_finish, w_finish_nxt;
  logic                r_playing, r_done;
  logic                w_step, w_active;
  logic [15:0]         w_lfsr;
  logic [10:0]         w_unused_lfsr;

  assign w_active      = Do_rand_audio_video | Do_save_audio_video;
  assign w_unused_lfsr = w_lfsr[15:5];

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .step  (w_step & ~Init_audio_video),
    .q     (w_lfsr)
  );

  // Next-state and datapath decode; abort on both enables low wins over normal progress.
  always_comb begin
    w_state_nxt  = r_state;
    w_mode_nxt   = r_mode;
    w_note_nxt   = r_note;
    w_len_nxt    = r_len;
    w_unit_nxt   = r_unit;
    w_pre_nxt    = r_pre;
    w_addr_nxt   = r_addr;
    w_finish_nxt = 1'b0;
    w_step       = 1'b0;
    case (r_state)
      IDLE: begin
        if (Do_save_audio_video) begin
          w_mode_nxt  = SCORE;
          w_state_nxt = FETCH;
        end else if (Do_rand_audio_video) begin
          w_mode_nxt  = RAND;
          w_state_nxt = FETCH;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      FETCH, LOAD, PLAY: begin
        if (!w_active) begin
          w_state_nxt = IDLE;
          w_addr_nxt  = '0;
          w_unit_nxt  = '0;
          w_pre_nxt   = '0;
        end else if (r_state == FETCH) begin
          w_state_nxt = LOAD;
        end else if (r_state == LOAD) begin
          if (r_mode == RAND) begin
            w_note_nxt   = fold_note(w_lfsr[4:0]);
            w_len_nxt    = LEN_W'(RAND_LEN);
            w_finish_nxt = 1'b1;
            w_step       = 1'b1;
            w_state_nxt  = PLAY;
          end else if (score_q[3:0] == 4'd0) begin
            w_state_nxt = DONE;
          end else begin
            w_note_nxt   = score_q[8:4];
            w_len_nxt    = score_q[3:0];
            w_finish_nxt = 1'b1;
            w_state_nxt  = PLAY;
          end
        end else if (r_pre != PRE_TOP) begin
          w_pre_nxt = r_pre + PRE_W'(1);
        end else begin
          w_pre_nxt = '0;
          if (LEN_W'(r_unit + 4'd1) != r_len) begin
            w_unit_nxt = r_unit + 4'd1;
          end else begin
            w_unit_nxt = '0;
            if (r_mode == RAND) begin
              w_state_nxt = FETCH;
            end else if (r_addr == ADDR_MAX) begin
              w_state_nxt = DONE;
            end else begin
              w_addr_nxt  = r_addr + ADDR_W'(1);
              w_state_nxt = FETCH;
            end
          end
        end
      end
      DONE: begin
        w_state_nxt = DONE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, datapath and registered output flags.
  always_ff @(posedge clk) begin
    if (reset || Init_audio_video) begin
      r_state   <= IDLE;
      r_mode    <= SCORE;
      r_note    <= '0;
      r_len     <= '0;
      r_unit    <= '0;
      r_pre     <= '0;
      r_addr    <= '0;
      r_finish  <= 1'b0;
      r_playing <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mode    <= w_mode_nxt;
      r_note    <= w_note_nxt;
      r_len     <= w_len_nxt;
      r_unit    <= w_unit_nxt;
      r_pre     <= w_pre_nxt;
      r_addr    <= w_addr_nxt;
      r_finish  <= w_finish_nxt;
      r_playing <= (w_state_nxt == FETCH) || (w_state_nxt == LOAD) || (w_state_nxt == PLAY);
      r_done    <= (w_state_nxt == DONE);
    end
  end

  assign score_addr = r_addr;
  assign note       = r_note;
  assign finish_len = r_finish;
  assign playing    = r_playing;
  assign done       = r_done;

endmodule

// File: tb/tb_score_player.sv
// Directed bench for score_player with a note scoreboard and a synchronous ROM model.
module tb_score_player;

  logic       clk = 1'b0;
  logic       reset, init_av, do_rand, do_save;
  logic [6:0] score_addr;
  logic [8:0] score_q;
  logic [4:0] note;
  logic       finish_len, playing, done;

  logic [8:0] rom [128];
  logic [4:0] exp_q [$];
  logic [15:0] m_lfsr;
  int n_assert = 0;
  int n_fail   = 0;
  int n, s;

  always #5 clk = ~clk;

  always_ff @(posedge clk) score_q <= rom[score_addr];

  score_player #(.ADDR_W(7), .TICK_DIV(4), .RAND_LEN(2), .LFSR_SEED(16'hACE1)) dut (
    .clk                 (clk),
    .reset               (reset),
    .Init_audio_video    (init_av),
    .Do_rand_audio_video (do_rand),
    .Do_save_audio_video (do_save),
    .score_addr          (score_addr),
    .score_q             (score_q),
    .note                (note),
    .finish_len          (finish_len),
    .playing             (playing),
    .done                (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [4:0] ref_note(input logic [15:0] v);
    logic [4:0] r;
    r = v[4:0];
    return (r >= 5'd24) ? (r - 5'd24) : r;
  endfunction

  task automatic push_rand(input int cnt);
    for (int k = 0; k < cnt; k++) begin
      exp_q.push_back(ref_note(m_lfsr));
      m_lfsr = lfsr_next(m_lfsr);
    end
  endtask

  // Waits for the next strobe, then checks latency and pops the expected note.
  task automatic next_note(input string tag, input int lat);
    logic [4:0] e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (finish_len !== 1'b1 && n < 40);
    check({tag, "_lat"}, n, lat);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 5'h1f;
    check({tag, "_note"}, note, e);
  endtask

  task automatic wait_done(input int budget);
    n = 0;
    s = 0;
    do begin
      @(negedge clk);
      n++;
      if (finish_len === 1'b1) s++;
    end while (done !== 1'b1 && n < budget);
  endtask

  task automatic pulse_init();
    init_av = 1'b1;
    @(negedge clk);
    init_av = 1'b0;
  endtask

  initial begin
    reset = 1'b1; init_av = 1'b0; do_rand = 1'b0; do_save = 1'b0;
    for (int k = 0; k < 128; k++) rom[k] = 9'h000;
    rom[0] = {5'd5, 4'd2};
    rom[1] = {5'd12, 4'd1};
    rom[2] = {5'd7, 4'd0};
    repeat (3) @(negedge clk);
    check("rst_note", note, 5'd0);
    check("rst_fin", finish_len, 1'b0);
    check("rst_addr", score_addr, 7'd0);
    check("rst_play", playing, 1'b0);
    check("rst_done", done, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Short score with end marker.
    exp_q.push_back(5'd5);
    exp_q.push_back(5'd12);
    do_save = 1'b1;
    next_note("s1", 3);
    check("s1_play", playing, 1'b1);
    @(negedge clk);
    check("s1_pulse", finish_len, 1'b0);
    exp_q.push_front(5'd12);
    exp_q.pop_back();
    next_note("s2", 9);
    check("s2_addr", score_addr, 7'd1);
    wait_done(20);
    check("s_done_lat", n, 6);
    check("s_no_strobe", s, 0);
    repeat (5) @(negedge clk);
    check("s_done_hold", done, 1'b1);
    check("s_note_hold", note, 5'd12);
    check("s_not_play", playing, 1'b0);
    check("s_no_fin", finish_len, 1'b0);

    // Both enables: score wins; then abort mid-PLAY and replay.
    do_save = 1'b0;
    pulse_init();
    check("init_done", done, 1'b0);
    check("init_note", note, 5'd0);
    exp_q.push_back(5'd5);
    exp_q.push_back(5'd12);
    do_save = 1'b1; do_rand = 1'b1;
    next_note("b1", 3);
    check("b1_addr", score_addr, 7'd0);
    next_note("b2", 10);
    check("b2_addr", score_addr, 7'd1);
    @(negedge clk);
    do_save = 1'b0; do_rand = 1'b0;
    @(negedge clk);
    check("ab_play", playing, 1'b0);
    check("ab_addr", score_addr, 7'd0);
    check("ab_note", note, 5'd12);
    check("ab_fin", finish_len, 1'b0);
    exp_q.push_back(5'd5);
    do_save = 1'b1;
    next_note("rp", 3);
    check("rp_addr", score_addr, 7'd0);
    do_save = 1'b0;
    repeat (2) @(negedge clk);

    // Random mode from the seed.
    m_lfsr = 16'hACE1;
    push_rand(6);
    do_rand = 1'b1;
    for (int k = 0; k < 6; k++) begin
      next_note($sformatf("r%0d", k), (k == 0) ? 3 : 10);
      check("r_lt24", (note < 5'd24), 1'b1);
      check("r_addr", score_addr, 7'd0);
    end
    @(negedge clk);
    do_rand = 1'b0;
    pulse_init();
    check("ri_note", note, 5'd0);
    push_rand(2);
    do_rand = 1'b1;
    next_note("ri0", 3);
    next_note("ri1", 10);
    do_rand = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_lfsr = 16'hACE1;
    push_rand(2);
    do_rand = 1'b1;
    next_note("rr0", 3);
    next_note("rr1", 10);
    do_rand = 1'b0;
    repeat (2) @(negedge clk);

    // Full ROM of len=1 notes: no wrap past the last entry.
    for (int k = 0; k < 128; k++) begin
      rom[k] = {5'(k % 24), 4'd1};
      exp_q.push_back(5'(k % 24));
    end
    do_save = 1'b1;
    for (int k = 0; k < 128; k++) begin
      next_note("f", (k == 0) ? 3 : 6);
    end
    check("f_last_addr", score_addr, 7'd127);
    wait_done(20);
    check("f_done_lat", n, 4);
    check("f_no_strobe", s, 0);
    repeat (10) @(negedge clk);
    check("f_addr_hold", score_addr, 7'd127);
    check("f_done_hold", done, 1'b1);
    check("f_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
